// File: rtl/fetch_stage.sv
// fetch_stage: PC sequencing, 1-cycle instruction memory fetch with skid buffer, stall and redirect handling
module fetch_stage #(
    parameter int PC_WIDTH = 16,
    parameter int IR_WIDTH = 32,
    parameter int ADDR_WIDTH = 10,
    parameter logic [PC_WIDTH-1:0] BOOT_PC = '0,
    parameter logic [PC_WIDTH-1:0] PC_STEP = PC_WIDTH'(4)
) (
    input  logic                  I_CLOCK,
    input  logic                  I_RESET_N,
    input  logic                  I_LOCK,
    input  logic                  I_DepStallSignal,
    input  logic                  I_BranchStallSignal,
    input  logic                  I_GPUStallSignal,
    input  logic [PC_WIDTH-1:0]   I_BranchPC,
    input  logic                  I_BranchAddrSelect,
    output logic [ADDR_WIDTH-1:0] O_IMemAddr,
    output logic                  O_IMemRdEn,
    input  logic [IR_WIDTH-1:0]   I_IMemData,
    output logic                  O_LOCK,
    output logic [PC_WIDTH-1:0]   O_PC,
    output logic [IR_WIDTH-1:0]   O_IR,
    output logic                  O_FE_Valid
);
    typedef enum logic {FETCH, BR_WAIT} state_t;
    state_t state, state_nx;
    logic [PC_WIDTH-1:0] pc, pend_pc, skid_pc;
    logic [IR_WIDTH-1:0] skid;
    logic pend, skid_v, hold;
    assign hold = I_DepStallSignal | I_GPUStallSignal;
    assign O_IMemAddr = pc[ADDR_WIDTH+1:2];
    always_ff @(posedge I_CLOCK or negedge I_RESET_N) begin
        if (!I_RESET_N) state <= FETCH;
        else if (I_LOCK) state <= state_nx;
    end
    always_comb begin
        state_nx = I_BranchAddrSelect ? FETCH :
                   (state == FETCH && !hold && I_BranchStallSignal) ? BR_WAIT : state;
    end
    always_comb begin
        O_IMemRdEn = I_RESET_N && I_LOCK && state == FETCH && !I_BranchAddrSelect && !hold && !I_BranchStallSignal;
    end
    always_ff @(posedge I_CLOCK or negedge I_RESET_N) begin
        if (!I_RESET_N) begin
            pc <= BOOT_PC;
            pend_pc <= '0;
            skid_pc <= '0;
            skid <= '0;
            pend <= 1'b0;
            skid_v <= 1'b0;
            O_LOCK <= 1'b0;
            O_PC <= '0;
            O_IR <= '0;
            O_FE_Valid <= 1'b0;
        end else begin
            O_LOCK <= I_LOCK;
            if (I_LOCK) begin
                if (I_BranchAddrSelect) begin
                    pc <= I_BranchPC;
                    pend <= 1'b0;
                    skid_v <= 1'b0;
                    O_FE_Valid <= 1'b0;
                end else if (state == BR_WAIT) begin
                    O_FE_Valid <= 1'b0;
                end else if (hold) begin
                    if (pend) begin
                        skid <= I_IMemData;
                        skid_pc <= pend_pc;
                        skid_v <= 1'b1;
                    end
                    pend <= 1'b0;
                end else if (I_BranchStallSignal) begin
                    pend <= 1'b0;
                    skid_v <= 1'b0;
                    O_FE_Valid <= 1'b0;
                end else begin
                    pc <= pc + PC_STEP;
                    pend <= 1'b1;
                    pend_pc <= pc;
                    skid_v <= 1'b0;
                    O_FE_Valid <= skid_v | pend;
                    if (skid_v) begin
                        O_IR <= skid;
                        O_PC <= skid_pc + PC_STEP;
                    end else if (pend) begin
                        O_IR <= I_IMemData;
                        O_PC <= pend_pc + PC_STEP;
                    end
                end
            end
        end
    end
endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: directed vectors for fetch_stage against a memory returning IR = word address
module tb_fetch_stage;
    logic I_CLOCK = 1'b0;
    logic I_RESET_N, I_LOCK, I_DepStallSignal, I_BranchStallSignal, I_GPUStallSignal, I_BranchAddrSelect;
    logic [15:0] I_BranchPC;
    logic [9:0] O_IMemAddr;
    logic O_IMemRdEn, O_LOCK, O_FE_Valid;
    logic [31:0] I_IMemData, O_IR;
    logic [15:0] O_PC;
    int vectors = 0;
    int errs = 0;
    fetch_stage dut (
        .I_CLOCK(I_CLOCK), .I_RESET_N(I_RESET_N), .I_LOCK(I_LOCK),
        .I_DepStallSignal(I_DepStallSignal), .I_BranchStallSignal(I_BranchStallSignal),
        .I_GPUStallSignal(I_GPUStallSignal), .I_BranchPC(I_BranchPC),
        .I_BranchAddrSelect(I_BranchAddrSelect), .O_IMemAddr(O_IMemAddr),
        .O_IMemRdEn(O_IMemRdEn), .I_IMemData(I_IMemData), .O_LOCK(O_LOCK),
        .O_PC(O_PC), .O_IR(O_IR), .O_FE_Valid(O_FE_Valid)
    );
    always #5 I_CLOCK = ~I_CLOCK;
    always @(posedge I_CLOCK) if (O_IMemRdEn) I_IMemData <= {22'b0, O_IMemAddr};
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask
    task automatic tick();
        @(posedge I_CLOCK);
        #1;
    endtask
    task automatic out(input string tag, input logic v, input logic [15:0] pc, input logic [31:0] ir);
        check({tag, "_valid"}, 32'(O_FE_Valid), 32'(v));
        if (v) begin
            check({tag, "_pc"}, 32'(O_PC), 32'(pc));
            check({tag, "_ir"}, O_IR, ir);
        end
    endtask
    initial begin
        I_RESET_N = 1'b0; I_LOCK = 1'b0; I_DepStallSignal = 1'b0; I_BranchStallSignal = 1'b0;
        I_GPUStallSignal = 1'b0; I_BranchAddrSelect = 1'b0; I_BranchPC = '0; I_IMemData = '0;
        #1;
        check("rst_valid", 32'(O_FE_Valid), 0);
        check("rst_pc", 32'(O_PC), 0);
        check("rst_ir", O_IR, 0);
        check("rst_lock", 32'(O_LOCK), 0);
        check("rst_rden", 32'(O_IMemRdEn), 0);
        tick(); tick();
        I_RESET_N = 1'b1; I_LOCK = 1'b1;
        #1;
        check("s1_rden", 32'(O_IMemRdEn), 1);
        check("s1_addr", 32'(O_IMemAddr), 0);
        tick(); out("s1_e1", 0, 0, 0);
        check("s1_lock", 32'(O_LOCK), 1);
        tick(); out("s1_e2", 1, 16'd4, 0);
        tick(); out("s1_e3", 1, 16'd8, 1);
        I_DepStallSignal = 1'b1;
        #1 check("s2_rden", 32'(O_IMemRdEn), 0);
        for (int i = 0; i < 3; i++) begin
            tick(); out("s2_hold", 1, 16'd8, 1);
        end
        I_DepStallSignal = 1'b0;
        tick(); out("s2_rel0", 1, 16'd12, 2);
        tick(); out("s2_rel1", 1, 16'd16, 3);
        I_BranchStallSignal = 1'b1;
        #1 check("s3_rden0", 32'(O_IMemRdEn), 0);
        tick();
        I_BranchStallSignal = 1'b0;
        out("s3_bub0", 0, 0, 0);
        for (int i = 0; i < 3; i++) begin
            #1 check("s3_rden", 32'(O_IMemRdEn), 0);
            tick(); out("s3_bub", 0, 0, 0);
        end
        I_BranchAddrSelect = 1'b1; I_BranchPC = 16'h0040;
        #1 check("s3_rden_sel", 32'(O_IMemRdEn), 0);
        tick(); out("s3_redir", 0, 0, 0);
        I_BranchAddrSelect = 1'b0;
        #1 check("s3_rden_go", 32'(O_IMemRdEn), 1);
        check("s3_addr", 32'(O_IMemAddr), 32'h10);
        tick(); out("s3_lat", 0, 0, 0);
        tick(); out("s3_first", 1, 16'h0044, 32'h10);
        I_DepStallSignal = 1'b1;
        tick(); out("s4_hold", 1, 16'h0044, 32'h10);
        I_BranchAddrSelect = 1'b1; I_BranchPC = 16'h0080;
        tick(); out("s4_redir", 0, 0, 0);
        I_BranchAddrSelect = 1'b0; I_DepStallSignal = 1'b0;
        #1 check("s4_addr", 32'(O_IMemAddr), 32'h20);
        tick(); out("s4_flush", 0, 0, 0);
        tick(); out("s4_first", 1, 16'h0084, 32'h20);
        I_LOCK = 1'b0;
        #1 check("s6_rden_off", 32'(O_IMemRdEn), 0);
        check("s6_lock_hold", 32'(O_LOCK), 1);
        for (int i = 0; i < 5; i++) begin
            tick(); out("s6_frozen", 1, 16'h0084, 32'h20);
            check("s6_lock", 32'(O_LOCK), 0);
            check("s6_rden", 32'(O_IMemRdEn), 0);
        end
        I_LOCK = 1'b1;
        tick(); out("s6_res0", 1, 16'h0088, 32'h21);
        check("s6_lock_on", 32'(O_LOCK), 1);
        tick(); out("s6_res1", 1, 16'h008C, 32'h22);
        I_BranchStallSignal = 1'b1;
        tick();
        I_BranchStallSignal = 1'b0;
        tick(); out("s5_brwait", 0, 0, 0);
        #2 I_RESET_N = 1'b0;
        #1;
        check("s5_valid", 32'(O_FE_Valid), 0);
        check("s5_pc", 32'(O_PC), 0);
        check("s5_ir", O_IR, 0);
        check("s5_lock", 32'(O_LOCK), 0);
        check("s5_rden", 32'(O_IMemRdEn), 0);
        check("s5_addr", 32'(O_IMemAddr), 0);
        tick();
        I_RESET_N = 1'b1;
        #1 check("s5_rden_go", 32'(O_IMemRdEn), 1);
        check("s5_addr_go", 32'(O_IMemAddr), 0);
        tick(); out("s5_e1", 0, 0, 0);
        tick(); out("s5_e2", 1, 16'd4, 0);
        tick(); out("s5_e3", 1, 16'd8, 1);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
        $finish;
    end
endmodule
